// File: rtl/sample_history_reg.sv
// sample_history_reg: current filter sample fk plus DEPTH past samples
// presented as a flat tap bus, with flush and fill/valid status.
//
// Parameters
//   N        half data width; a sample is 2*N bits (opaque, bit-exact)
//   DEPTH    number of past samples held (1..16)
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (highest priority)
//   In       new sample, registered into fk every cycle
//   shift    advance history by one place
//   clr      flush history and fill count (overrides shift)
//   fk       current sample register
//   hist     taps; slice j = f(k-1-j)
//   fill_cnt number of valid history entries
//   primed   fill_cnt == DEPTH
//   hist_vld one-cycle pulse after each history update
//
// Build option: define SAMPLE_HIST_FILL_EN to build the fill counter
// and the hist_vld pulse. Without it fill_cnt is tied to DEPTH,
// primed to 1 and hist_vld to 0.

module sample_history_reg #(
    parameter int N     = 25,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*N-1:0]             In,
    input  logic                       shift,
    input  logic                       clr,
    output logic [2*N-1:0]             fk,
    output logic [DEPTH*2*N-1:0]       hist,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
    output logic                       primed,
    output logic                       hist_vld
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Packed array so the flat tap bus is a plain alias:
    // taps[j] occupies bits [(j+1)*W-1 : j*W].
    logic [DEPTH-1:0][W-1:0] taps;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fk   <= '0;
            taps <= '0;
        end else begin
            fk <= In;
            if (clr) begin
                taps <= '0;
            end else if (shift) begin
                // Slice 0 takes the registered fk, not the incoming In.
                taps[0] <= fk;
                for (int j = 1; j < DEPTH; j++) begin
                    taps[j] <= taps[j-1];
                end
            end
        end
    end

    assign hist = taps;

`ifdef SAMPLE_HIST_FILL_EN

    logic [CW-1:0] cnt;
    logic          vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            vld <= 1'b0;
        end else begin
            vld <= shift & ~clr;
            if (clr) begin
                cnt <= '0;
            end else if (shift && (cnt != FULL)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign fill_cnt = cnt;
    assign primed   = (cnt == FULL);
    assign hist_vld = vld;

`else

    assign fill_cnt = FULL;
    assign primed   = 1'b1;
    assign hist_vld = 1'b0;

`endif

endmodule
